// File: rtl/imm_pkg.sv
// Shared types for the immediate generator queue: format enum, RV opcodes and the
// stored queue entry (sized for the widest XLEN; narrower builds trim the upper bits).
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I     = 3'd0,
        IMM_S     = 3'd1,
        IMM_B     = 3'd2,
        IMM_J     = 3'd3,
        IMM_U     = 3'd4,
        IMM_Z     = 3'd5,
        IMM_SHAMT = 3'd6,
        IMM_NONE  = 3'd7
    } imm_src_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int unsigned XLEN_MAX = 64;

    typedef struct packed {
        logic [31:0]          instr;
        imm_src_t             src;
        logic [XLEN_MAX-1:0]  imm;
        logic [XLEN_MAX-1:0]  target;
    } imm_entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV immediate decode: picks the format from the opcode, extends the
// immediate to XLEN and forms the PC-relative target for B, J and AUIPC.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    output imm_src_t        src_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] target_o
);

    logic [2:0]         funct3;
    logic signed [11:0] i_imm;
    logic signed [11:0] s_imm;
    logic signed [12:0] b_imm;
    logic signed [20:0] j_imm;
    logic signed [31:0] u_imm;
    logic [5:0]         shamt;
    logic               is_rel;

    assign funct3 = instr_i[14:12];
    assign i_imm  = instr_i[31:20];
    assign s_imm  = {instr_i[31:25], instr_i[11:7]};
    assign b_imm  = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign j_imm  = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign u_imm  = {instr_i[31:12], 12'b0};
    // RV32 shifts only use 5 bits; bit 25 belongs to funct7 there.
    assign shamt  = (XLEN == 64) ? instr_i[25:20] : {1'b0, instr_i[24:20]};

    always_comb begin
        src_o = IMM_NONE;
        case (instr_i[6:0])
            OP_LOAD, OP_JALR: src_o = IMM_I;
            OP_IMM: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) src_o = IMM_SHAMT;
                else                                       src_o = IMM_I;
            end
            OP_STORE:        src_o = IMM_S;
            OP_BRANCH:       src_o = IMM_B;
            OP_JAL:          src_o = IMM_J;
            OP_LUI, OP_AUIPC: src_o = IMM_U;
            OP_SYSTEM: begin
                if (funct3[2]) src_o = IMM_Z;
            end
            default: ;
        endcase
    end

    always_comb begin
        imm_o = '0;
        case (src_o)
            IMM_I:     imm_o = XLEN'(i_imm);
            IMM_S:     imm_o = XLEN'(s_imm);
            IMM_B:     imm_o = XLEN'(b_imm);
            IMM_J:     imm_o = XLEN'(j_imm);
            IMM_U:     imm_o = XLEN'(u_imm);
            IMM_Z:     imm_o = XLEN'(instr_i[19:15]);
            IMM_SHAMT: imm_o = XLEN'(shamt);
            default:   imm_o = '0;
        endcase
    end

    assign is_rel   = (src_o == IMM_B) || (src_o == IMM_J) || (instr_i[6:0] == OP_AUIPC);
    assign target_o = is_rel ? (pc_i + imm_o) : '0;

endmodule

// File: rtl/imm_gen_queue.sv
// Immediate generator feeding a DEPTH-entry decode FIFO between fetch and execute.
// Outputs come only from registered storage; empty queue drives zeros and NONE.
module imm_gen_queue
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [XLEN-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output imm_src_t                 out_src,
    output logic [XLEN-1:0]          out_imm,
    output logic [XLEN-1:0]          out_target,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    imm_src_t        dec_src;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] dec_target;
    imm_entry_t      wr_entry;
    imm_entry_t      head;
    imm_entry_t      mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_i  (in_instr),
        .pc_i     (in_pc),
        .src_o    (dec_src),
        .imm_o    (dec_imm),
        .target_o (dec_target)
    );

    // Full check uses registered count only: no pop pass-through into a full queue.
    assign in_ready  = !rst && (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_entry.instr  = in_instr;
        wr_entry.src    = dec_src;
        wr_entry.imm    = XLEN_MAX'(dec_imm);
        wr_entry.target = XLEN_MAX'(dec_target);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign head       = mem_q[rd_ptr_q];
    assign out_instr  = out_valid ? head.instr : '0;
    assign out_src    = out_valid ? head.src : IMM_NONE;
    assign out_imm    = out_valid ? XLEN'(head.imm) : '0;
    assign out_target = out_valid ? XLEN'(head.target) : '0;
    assign count      = count_q;

endmodule

// File: doc/imm_gen_queue.md
# imm_gen_queue

Parametrised immediate generator with a built-in decode queue, sitting between instruction fetch and the register-read/execute stages. Accepts a stream of 32-bit RV instructions with their PCs over a valid/ready handshake. Derives the immediate format from the opcode itself; no external select is needed. Each entry stores the XLEN-wide extended immediate and a PC-relative target in a DEPTH-entry FIFO that execute drains with its own handshake.

## Interface
- XLEN, 32: datapath width, 32 or 64.
- DEPTH, 4: queue entries, power of two, ≥ 2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous queue clear (branch mispredict/trap).
- in_valid  in  1  instruction offered.
- in_ready  out  1  queue can accept this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer takes head this cycle.
- out_instr  out  32  head instruction.
- out_src  out  3  imm_src_t of head.
- out_imm  out  XLEN  extended immediate of head.
- out_target  out  XLEN  PC-relative target of head.
- count  out  $clog2(DEPTH)+1  entries held.

## Operation
- Format select from opcode in_instr[6:0]:
  - 0000011 (load) and 1100111 (JALR): I.
  - 0010011 (OP-IMM): I; SHAMT when funct3 = 001 or 101.
  - 0100011: S.
  - 1100011: B.
  - 1101111: J.
  - 0110111 (LUI) and 0010111 (AUIPC): U.
  - 1110011 with funct3[2] = 1: Z.
  - Anything else: NONE.
- Immediate values (sign extension is from instr[31] to XLEN):
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - U: sext({instr[31:12], 12'b0}).
  - SHAMT: zero-extended instr[24:20] when XLEN = 32, instr[25:20] when XLEN = 64; funct7 bits never appear in imm.
  - Z: zero-extended instr[19:15].
  - NONE: 0.
- Target:
  - in_pc + imm, modulo 2^XLEN (wraps, no overflow flag), for B, J and AUIPC.
  - 0 for all other formats, including JALR.
- Queue behaviour:
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
  - FIFO order is strict.
  - Read/write pointers wrap at DEPTH.
- Flow control and boundaries:
  - in_ready = !rst && (count < DEPTH). It is based on registered count only; there is no same-cycle pop pass-through, so a full queue rejects a push even when a pop occurs that cycle.
  - Simultaneous push and pop when not full: count unchanged, both take effect.
  - Empty: out_valid = 0, and out_instr, out_src (NONE), out_imm and out_target drive 0.
- Priority: rst > flush > push/pop.
  - flush zeroes pointers and count; any push or pop in that cycle is discarded.
  - rst mid-operation behaves identically to flush.
- Reset values: count 0, out_valid 0, out_* 0, out_src NONE, in_ready 0 while rst is high and 1 in the first cycle after.

## Timing
- Decode is combinational on the input side. The entry is written at the accept edge N.
- out_valid rises after edge N, i.e. 1-cycle latency from accept to head visibility when the queue was empty.
- out_* are driven from registered storage and pointers only; there is no combinational path from in_* to out_*.
- in_ready depends only on registered state and rst; it never depends on in_valid or out_ready.
- Throughput: 1 instruction/cycle sustained when out_ready is held high.

## Structure
- Package imm_pkg holds:
  - imm_src_t (3-bit enum): I=0, S=1, B=2, J=3, U=4, Z=5, SHAMT=6, NONE=7.
  - Opcode localparams: OP_LOAD, OP_IMM, OP_JALR, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI, OP_AUIPC, OP_SYSTEM.
  - Queue entry struct: instr, src, imm, target.
- Sub-module imm_decode, combinational and parametrised by XLEN: instr + pc → src, imm, target. The top level imm_gen_queue holds the FIFO storage, pointers, count and handshake.

## Test plan
- XLEN=32, pc 0x0, 0xFFF00093 (ADDI x1,x0,-1) accepted → next cycle out_valid=1, src I, imm 0xFFFFFFFF, target 0.
- XLEN=32, pc 0x1000, 0xFE000EE3 (BEQ −4) → src B, imm 0xFFFFFFFC, target 0x00000FFC.
- XLEN=64, pc 0x0, 0x80000017 (AUIPC 0x80000) → src U, imm and target 0xFFFFFFFF80000000.
- XLEN=32, 0x4030D093 (SRAI x1,x1,3) → src SHAMT, imm 0x3 (not 0x403).
- DEPTH=4, out_ready=0, push 4 entries → count 4, in_ready 0. Then one cycle with out_ready=1 and in_valid=1 → only the pop occurs, count 3, in_ready 1 next cycle, and entries drain in push order.
- count=3, flush=1 with in_valid=1 → next cycle count 0, out_valid 0, offered instruction dropped. Repeat with rst instead of flush → same result, and in_ready 0 during rst.
